rgb_fifo_burst_writer: RTL and testbench
========================================

# rgb_fifo_burst_writer

Read-side consumer of the 16-bit RGB565 dual-clock pixel FIFO (64 words, normal/non-show-ahead mode). Runs in the FIFO read-clock domain. Waits until the FIFO holds a full burst, then issues a write-burst request to the SDRAM frame-buffer controller and streams the words out as the controller pulls them. Generates linearly incrementing frame-buffer addresses and signals end of frame.

## Interface
Parameters:
- BURST_LEN, 8, words per burst; legal 1..32.
- ADDR_W, 22, SDRAM word-address width.
- BASE_ADDR, 0, first word address of the frame buffer.
- FRAME_WORDS, 76800, words per frame (320x240); must be ≥1.

Ports:
- rdclk  in  1  FIFO read-domain clock; the only clock.
- sclr  in  1  synchronous active-high reset; sampled on rdclk rising edge.
- fifo_q  in  16  FIFO read data; valid the cycle after fifo_rdreq.
- fifo_rdempty  in  1  FIFO empty.
- fifo_rdusedw  in  6  FIFO fill level, read domain.
- fifo_rdreq  out  1  FIFO read strobe.
- frame_start  in  1  one-cycle pulse; restarts the address at BASE_ADDR.
- wr_req  out  1  burst request to the SDRAM controller.
- wr_addr  out  ADDR_W  burst start word address; stable while wr_req=1.
- wr_len  out  6  burst length in words; stable while wr_req=1.
- wr_ack  in  1  one-cycle burst acceptance.
- wr_data_req  in  1  controller pulls one word; it samples wr_data on the next cycle.
- wr_data  out  16  equals fifo_q (combinational pass-through).
- frame_done  out  1  one-cycle pulse after the last word of a frame.
- underrun  out  1  sticky error flag.

## Operation
- Registered state: ptr (ADDR_W bits, offset from BASE_ADDR), remaining (width ceil(log2(FRAME_WORDS+1))), cnt (6 bits), len (6 bits), pend_start (1 bit).
- len_next = min(BURST_LEN, remaining).
- FSM states:
  - IDLE:
    - If pend_start or frame_start: set ptr=0, remaining=FRAME_WORDS, clear pend_start, and stay in IDLE this cycle.
    - Otherwise, if fifo_rdusedw ≥ len_next and fifo_rdempty=0: latch len=len_next and go to REQ.
  - REQ:
    - wr_req=1, wr_addr=BASE_ADDR+ptr (mod 2^ADDR_W), wr_len=len.
    - On wr_ack: cnt=0, go to DATA.
  - DATA:
    - fifo_rdreq = wr_data_req & (cnt<len) & !fifo_rdempty.
    - cnt increments on each fifo_rdreq.
    - wr_data_req with cnt<len and fifo_rdempty=1: no read, underrun set to 1, cnt still increments so the burst length is preserved; the controller receives stale data.
    - wr_data_req with cnt=len: ignored.
    - When cnt=len: go to LAST.
  - LAST (one cycle, lets the final word land on fifo_q):
    - ptr += len; remaining -= len.
    - If the new remaining=0: pulse frame_done, set remaining=FRAME_WORDS and ptr=0.
    - Go to IDLE.
- frame_start arriving outside IDLE sets pend_start. It is applied on the next IDLE cycle; the current burst completes unaffected.
- A tail burst is shorter than BURST_LEN when FRAME_WORDS is not a multiple of BURST_LEN.
- underrun clears only on sclr.

## Timing
- Reset values, from sclr at a clock edge:
  - state=IDLE; wr_req=0; fifo_rdreq=0; wr_len=0; wr_addr=BASE_ADDR; frame_done=0; underrun=0.
  - ptr=0; remaining=FRAME_WORDS; pend_start=0.
  - wr_data follows fifo_q and is not reset.
- sclr mid-burst aborts immediately. No further fifo_rdreq is issued, and the controller must be reset alongside.
- Threshold met at edge N → wr_req=1 from cycle N+1.
- wr_ack at cycle M → DATA from M+1. The first fifo_rdreq can coincide with a wr_data_req at M+1.
- fifo_rdreq is combinational from wr_data_req, with zero cycles of latency. wr_data is valid one cycle after each fifo_rdreq.
- Minimum burst-to-burst turnaround: LAST + IDLE + REQ = 3 cycles plus wr_ack latency.
- fifo_rdusedw lags writes; it is used only as a lower bound and never causes an over-read.
- ptr arithmetic wraps modulo 2^ADDR_W.

## Test plan
- BURST_LEN=8, FIFO filled with 0x0001..0x0008, wr_ack after 2 cycles, wr_data_req held high → wr_req with wr_addr=0, wr_len=8; exactly 8 fifo_rdreq; wr_data sequence 0x0001..0x0008; wr_req is not re-asserted while rdusedw<8.
- FRAME_WORDS=20, BURST_LEN=8, continuous fill → bursts (addr,len) = (0,8), (8,8), (16,4); frame_done pulses once after the 4th tail word; the next burst addr=0.
- wr_data_req gapped 1-on/2-off → fifo_rdreq mirrors the gaps; burst still ends after 8 reads; extra wr_data_req in LAST produces no read.
- frame_start pulsed mid-DATA at ptr=8 → current burst finishes; the next burst has wr_addr=BASE_ADDR; frame_done does not pulse.
- Force fifo_rdempty=1 during DATA with wr_data_req=1 → fifo_rdreq=0, underrun=1 and stays 1 until sclr.
- sclr asserted mid-DATA → next cycle: wr_req=0, fifo_rdreq=0, wr_addr=BASE_ADDR, underrun=0, state IDLE.

Source files
------------

// File: rtl/rgb_fifo_burst_writer.sv
`default_nettype none
// ============================================================================
// Module      : rgb_fifo_burst_writer
// Description : Read-side consumer of a 16-bit RGB565 dual-clock pixel FIFO
//               (normal, non-show-ahead). Waits for a full burst's worth of
//               pixels, requests an SDRAM write burst, streams FIFO words to
//               the controller as it pulls them, and walks a linear
//               frame-buffer address with an end-of-frame pulse.
// Ports       : rdclk/sclr      - read-domain clock, sync active-high reset
//               fifo_*          - FIFO read side (q, rdempty, rdusedw, rdreq)
//               frame_start     - restart addressing at BASE_ADDR
//               wr_req/addr/len - burst request, held until wr_ack
//               wr_data_req     - controller pulls one word (lands next cycle)
//               wr_data         - combinational copy of fifo_q
//               frame_done      - one-cycle pulse after last word of a frame
//               underrun        - sticky: a word was pulled from an empty FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_fifo_burst_writer #(
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 76800
) (
  input  logic              rdclk,
  input  logic              sclr,
  input  logic [15:0]       fifo_q,
  input  logic              fifo_rdempty,
  input  logic [5:0]        fifo_rdusedw,
  output logic              fifo_rdreq,
  input  logic              frame_start,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [5:0]        wr_len,
  input  logic              wr_ack,
  input  logic              wr_data_req,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              underrun
);

  localparam int unsigned       REM_W   = $clog2(FRAME_WORDS + 1);
  localparam logic [5:0]        C_BURST = 6'(BURST_LEN);
  localparam logic [REM_W-1:0]  C_FRAME = REM_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_LAST = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [REM_W-1:0]    remaining_q;
  logic [5:0]          cnt_q;
  logic [5:0]          len_q;
  logic                pend_start_q;
  logic                wr_req_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [5:0]          wr_len_q;
  logic                frame_done_q;
  logic                underrun_q;

  logic [5:0]          len_next;
  logic [REM_W-1:0]    rem_after;
  logic                slot_open;

  always_comb begin
    // Tail burst of a frame is clipped to what is left of the frame.
    if (32'(remaining_q) < BURST_LEN) begin
      len_next = 6'(remaining_q);
    end else begin
      len_next = C_BURST;
    end
    rem_after = remaining_q - REM_W'(len_q);
    // A controller pull that still belongs to the current burst. It consumes
    // a burst slot even if the FIFO is empty so the burst length holds.
    slot_open  = (state_q == S_DATA) && wr_data_req && (cnt_q < len_q);
    // Gated by sclr so a reset mid-burst issues no further reads at once.
    fifo_rdreq = slot_open && !fifo_rdempty && !sclr;
  end

  assign wr_data    = fifo_q;
  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign wr_len     = wr_len_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

  always_ff @(posedge rdclk) begin
    if (sclr) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      remaining_q  <= C_FRAME;
      cnt_q        <= '0;
      len_q        <= '0;
      pend_start_q <= 1'b0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= C_BASE;
      wr_len_q     <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // A restart seen mid-burst is deferred until the burst is over.
      if (frame_start && (state_q != S_IDLE)) begin
        pend_start_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (pend_start_q || frame_start) begin
            ptr_q        <= '0;
            remaining_q  <= C_FRAME;
            pend_start_q <= 1'b0;
          end else if (!fifo_rdempty && (fifo_rdusedw >= len_next)) begin
            len_q     <= len_next;
            wr_len_q  <= len_next;
            wr_addr_q <= C_BASE + ptr_q;
            wr_req_q  <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (wr_ack) begin
            wr_req_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_DATA;
          end
        end
        S_DATA: begin
          if (slot_open) begin
            cnt_q <= cnt_q + 6'd1;
            if (fifo_rdempty) begin
              underrun_q <= 1'b1;
            end
          end
          if (cnt_q == len_q) begin
            state_q <= S_LAST;
          end
        end
        S_LAST: begin
          // Final word is on fifo_q during this cycle; advance the address.
          if (rem_after == '0) begin
            frame_done_q <= 1'b1;
            remaining_q  <= C_FRAME;
            ptr_q        <= '0;
          end else begin
            ptr_q       <= ptr_q + ADDR_W'(len_q);
            remaining_q <= rem_after;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_fifo_burst_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_fifo_burst_writer
// Description : Self-checking bench for rgb_fifo_burst_writer with a small
//               FIFO model and a directed SDRAM-controller model.
//               DUT: BURST_LEN=8, FRAME_WORDS=20, BASE_ADDR=0x100.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_fifo_burst_writer;

  localparam int unsigned ADDR_W = 22;

  logic              clk = 1'b0;
  logic              sclr = 1'b1;
  logic [15:0]       fifo_q = 16'h0000;
  logic              fifo_rdempty;
  logic [5:0]        fifo_rdusedw;
  logic              fifo_rdreq;
  logic              frame_start = 1'b0;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [5:0]        wr_len;
  logic              wr_ack = 1'b0;
  logic              wr_data_req = 1'b0;
  logic [15:0]       wr_data;
  logic              frame_done;
  logic              underrun;

  rgb_fifo_burst_writer #(
    .BURST_LEN  (8),
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (32'h100),
    .FRAME_WORDS(20)
  ) dut (
    .rdclk       (clk),
    .sclr        (sclr),
    .fifo_q      (fifo_q),
    .fifo_rdempty(fifo_rdempty),
    .fifo_rdusedw(fifo_rdusedw),
    .fifo_rdreq  (fifo_rdreq),
    .frame_start (frame_start),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_len      (wr_len),
    .wr_ack      (wr_ack),
    .wr_data_req (wr_data_req),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // FIFO model: words pushed by the stimulus, popped on fifo_rdreq.
  logic [15:0] mem [0:255];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          fill;
  logic        force_empty = 1'b0;
  logic [15:0] push_val = 16'h0001;

  assign fill         = wr_cnt - rd_cnt;
  assign fifo_rdusedw = (fill > 63) ? 6'd63 : fill[5:0];
  assign fifo_rdempty = (fill == 0) || force_empty;

  always @(posedge clk) begin
    if (fifo_rdreq && (fill > 0)) begin
      fifo_q <= mem[rd_cnt[7:0]];
      rd_cnt <= rd_cnt + 1;
    end
  end

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_word = 16'h0001;

  typedef struct {
    int                gap;
    int                fs_at;
    logic [ADDR_W-1:0] addr;
    int                len;
    int                done;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_cnt[7:0]] = push_val;
      push_val = push_val + 16'd1;
      wr_cnt = wr_cnt + 1;
    end
  endtask

  task automatic wait_req(output bit ok);
    for (int i = 0; i < 60 && !wr_req; i++) @(negedge clk);
    ok = wr_req;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_req: got wr_req=0 expected 1 within 60 cycles");
    end
  endtask

  // Acknowledge two cycles after the request is seen.
  task automatic do_ack();
    @(negedge clk);
    @(negedge clk);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    check("req_drop_after_ack", {31'd0, wr_req}, 32'd0);
  endtask

  task automatic run_burst(input vec_t v, input int idx);
    bit ok;
    int pulled, reads, guard, phase, extra, dn;
    bit prev, req;
    wait_req(ok);
    if (!ok) return;
    check($sformatf("v%0d_addr", idx), 32'(wr_addr), 32'(v.addr));
    check($sformatf("v%0d_len", idx), 32'(wr_len), 32'(v.len));
    do_ack();
    pulled = 0; reads = 0; guard = 0; phase = 0; prev = 1'b0;
    while ((pulled < v.len || prev) && guard < 200) begin
      if (prev) begin
        check($sformatf("v%0d_data", idx), 32'(wr_data), 32'(exp_word));
        exp_word = exp_word + 16'd1;
      end
      req = (pulled < v.len) && (phase == 0);
      if (req) pulled++;
      phase = (phase == v.gap) ? 0 : phase + 1;
      wr_data_req = req;
      frame_start = (guard == v.fs_at);
      #1;
      if (fifo_rdreq) reads++;
      check($sformatf("v%0d_rdreq_mirror", idx), {31'd0, fifo_rdreq}, {31'd0, req});
      prev = req;
      @(negedge clk);
      guard++;
    end
    frame_start = 1'b0;
    check($sformatf("v%0d_reads", idx), 32'(reads), 32'(v.len));
    // Pulls after the burst is complete must not read the FIFO.
    extra = 0; dn = 0;
    for (int i = 0; i < 5; i++) begin
      wr_data_req = 1'b1;
      #1;
      if (fifo_rdreq) extra++;
      if (frame_done) dn++;
      @(negedge clk);
    end
    wr_data_req = 1'b0;
    check($sformatf("v%0d_extra_reads", idx), 32'(extra), 32'd0);
    check($sformatf("v%0d_frame_done", idx), 32'(dn), 32'(v.done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int n;
    vecs[0] = '{gap: 0, fs_at: -1, addr: 22'h100, len: 8, done: 0};
    vecs[1] = '{gap: 2, fs_at: -1, addr: 22'h108, len: 8, done: 0};
    vecs[2] = '{gap: 0, fs_at: -1, addr: 22'h110, len: 4, done: 1};
    vecs[3] = '{gap: 1, fs_at: -1, addr: 22'h100, len: 8, done: 0};
    vecs[4] = '{gap: 0, fs_at: 3,  addr: 22'h108, len: 8, done: 0};
    vecs[5] = '{gap: 0, fs_at: -1, addr: 22'h100, len: 8, done: 0};

    repeat (3) @(negedge clk);
    check("rst_wr_req", {31'd0, wr_req}, 32'd0);
    check("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    check("rst_wr_len", 32'(wr_len), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'h100);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    sclr = 1'b0;

    // Below threshold: no request.
    push(5);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_req) n++;
    end
    check("no_req_below_threshold", 32'(n), 32'd0);
    push(3);
    push(60);

    for (int i = 0; i < 6; i++) run_burst(vecs[i], i);

    // Underrun: first pull of the burst hits an empty FIFO.
    wait_req(ok);
    if (ok) begin
      check("ur_addr", 32'(wr_addr), 32'h108);
      do_ack();
      force_empty = 1'b1;
      wr_data_req = 1'b1;
      #1;
      check("ur_rdreq_blocked", {31'd0, fifo_rdreq}, 32'd0);
      @(negedge clk);
      force_empty = 1'b0;
      check("ur_flag_set", {31'd0, underrun}, 32'd1);
      n = 0;
      for (int i = 0; i < 9; i++) begin
        wr_data_req = 1'b1;
        #1;
        if (fifo_rdreq) n++;
        @(negedge clk);
      end
      wr_data_req = 1'b0;
      check("ur_reads", 32'(n), 32'd7);
      repeat (4) @(negedge clk);
      check("ur_flag_sticky", {31'd0, underrun}, 32'd1);
    end

    // Reset in the middle of the tail burst.
    wait_req(ok);
    if (ok) begin
      check("sc_addr", 32'(wr_addr), 32'h110);
      check("sc_len", 32'(wr_len), 32'd4);
      do_ack();
      for (int i = 0; i < 2; i++) begin
        wr_data_req = 1'b1;
        @(negedge clk);
      end
      sclr = 1'b1;
      wr_data_req = 1'b1;
      @(negedge clk);
      check("sc_wr_req", {31'd0, wr_req}, 32'd0);
      check("sc_rdreq", {31'd0, fifo_rdreq}, 32'd0);
      check("sc_wr_addr", 32'(wr_addr), 32'h100);
      check("sc_wr_len", 32'(wr_len), 32'd0);
      check("sc_underrun", {31'd0, underrun}, 32'd0);
      sclr = 1'b0;
      wr_data_req = 1'b0;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
